// File: rtl/float_regfile_mp.sv
// Floating-point register file: 3 async read ports, 1-2 writeback ports, busy scoreboard,
// NaN-boxing of single-precision writes and a hardware clear sequence. Optional macro: FRF_BYPASS_EN.
module float_regfile_mp #(
   parameter int FLEN         = 32,
   parameter int NUM_WR_PORTS = 2,
   parameter int NUM_REGS     = 32
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   output logic                         ready_o,
   input  logic [4:0]                   rs1_i,
   input  logic [4:0]                   rs2_i,
   input  logic [4:0]                   rs3_i,
   output logic [FLEN-1:0]              read_data1_o,
   output logic [FLEN-1:0]              read_data2_o,
   output logic [FLEN-1:0]              read_data3_o,
   output logic                         busy1_o,
   output logic                         busy2_o,
   output logic                         busy3_o,
   input  logic                         issue_valid_i,
   input  logic [4:0]                   issue_rd_i,
   input  logic [NUM_WR_PORTS-1:0]      wr_en_i,
   input  logic [5*NUM_WR_PORTS-1:0]    wr_addr_i,
   input  logic [FLEN*NUM_WR_PORTS-1:0] wr_data_i,
   input  logic [NUM_WR_PORTS-1:0]      wr_single_i,
   output logic                         wr_conflict_o
);

   typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

   // Upper half forced to ones for a boxed single; collapses to zero when FLEN is 32.
   localparam logic [FLEN-1:0] BOX_MASK = {FLEN{1'b1}} << 6'd32;

   state_t              state_r, state_s;
   logic [4:0]          clr_cnt_r;
   logic                ready_r;
   logic                conflict_r, conflict_s;
   logic [FLEN-1:0]     regs_r [NUM_REGS];
   logic [NUM_REGS-1:0] busy_r;
   logic [4:0]          rs_s [3];
   logic [FLEN-1:0]     rd_data_s [3];
   logic                rd_busy_s [3];

   function automatic logic [FLEN-1:0] nan_box(input logic [FLEN-1:0] data, input logic single);
      return single ? (data | BOX_MASK) : data;
   endfunction

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r <= INIT;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic: leave INIT after register 31 has been cleared
   always_comb begin
      state_s = state_r;
      case (state_r)
         INIT: begin
            if (clr_cnt_r == 5'd31) begin
               state_s = RUN;
            end else begin
               state_s = INIT;
            end
         end
         RUN:     state_s = RUN;
         default: state_s = INIT;
      endcase
   end

   // Same-address detection across every pair of enabled write ports
   always_comb begin
      conflict_s = 1'b0;
      for (int j = 0; j < NUM_WR_PORTS; j++) begin
         for (int k = j + 1; k < NUM_WR_PORTS; k++) begin
            if (wr_en_i[j] && wr_en_i[k] && (wr_addr_i[5*j +: 5] == wr_addr_i[5*k +: 5])) begin
               conflict_s = 1'b1;
            end else begin
               conflict_s = conflict_s;
            end
         end
      end
   end

   // Register array, scoreboard, clear counter and registered status outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         clr_cnt_r  <= 5'd0;
         ready_r    <= 1'b0;
         conflict_r <= 1'b0;
      end else if (state_r == INIT) begin
         regs_r[clr_cnt_r] <= {FLEN{1'b0}};
         busy_r[clr_cnt_r] <= 1'b0;
         clr_cnt_r         <= clr_cnt_r + 5'd1;
         ready_r           <= (clr_cnt_r == 5'd31);
         conflict_r        <= 1'b0;
      end else begin
         ready_r    <= 1'b1;
         conflict_r <= conflict_s;
         // Ascending port order lets the higher-index port win on a shared address.
         for (int k = 0; k < NUM_WR_PORTS; k++) begin
            if (wr_en_i[k]) begin
               regs_r[wr_addr_i[5*k +: 5]] <= nan_box(wr_data_i[FLEN*k +: FLEN], wr_single_i[k]);
               busy_r[wr_addr_i[5*k +: 5]] <= 1'b0;
            end
         end
         // A new producer supersedes a completing one, so the set comes last.
         if (issue_valid_i) begin
            busy_r[issue_rd_i] <= 1'b1;
         end
      end
   end

   assign rs_s[0] = rs1_i;
   assign rs_s[1] = rs2_i;
   assign rs_s[2] = rs3_i;

   // Read ports: stored state, optionally overridden by same-cycle writeback
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         rd_data_s[i] = regs_r[rs_s[i]];
         rd_busy_s[i] = busy_r[rs_s[i]];
`ifdef FRF_BYPASS_EN
         for (int k = 0; k < NUM_WR_PORTS; k++) begin
            rd_data_s[i] = (wr_en_i[k] && (wr_addr_i[5*k +: 5] == rs_s[i]))
                         ? nan_box(wr_data_i[FLEN*k +: FLEN], wr_single_i[k]) : rd_data_s[i];
            rd_busy_s[i] = (wr_en_i[k] && (wr_addr_i[5*k +: 5] == rs_s[i]))
                         ? (issue_valid_i && (issue_rd_i == rs_s[i])) : rd_busy_s[i];
         end
`else
`endif
      end
   end

   assign read_data1_o  = (state_r == RUN) ? rd_data_s[0] : {FLEN{1'b0}};
   assign read_data2_o  = (state_r == RUN) ? rd_data_s[1] : {FLEN{1'b0}};
   assign read_data3_o  = (state_r == RUN) ? rd_data_s[2] : {FLEN{1'b0}};
   assign busy1_o       = (state_r == RUN) ? rd_busy_s[0] : 1'b1;
   assign busy2_o       = (state_r == RUN) ? rd_busy_s[1] : 1'b1;
   assign busy3_o       = (state_r == RUN) ? rd_busy_s[2] : 1'b1;
   assign ready_o       = ready_r;
   assign wr_conflict_o = conflict_r;

endmodule

// File: doc/float_regfile_mp.md
Name: float_regfile_mp

Overview:
- Next-generation floating-point register file for the decode stage.
- Width is parametrised to FLEN (32 for F, 64 for D) and it has up to two writeback ports.
- Adds a per-register busy scoreboard, NaN-boxing of single-precision writes, and a sequenced hardware clear after reset.
- Three asynchronous read ports feed the FP execute units (fmadd needs rs3). f0 is an ordinary writable register.

Parameters:
- FLEN, 32, register data width; legal values 32 or 64.
- NUM_WR_PORTS, 2, number of writeback ports; legal values 1 or 2.
- NUM_REGS, 32, register count; fixed at 32 (5-bit addresses).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- ready_o  out  1  high once the clear sequence has finished
- rs1_i  in  5  read address 1
- rs2_i  in  5  read address 2
- rs3_i  in  5  read address 3
- read_data1_o  out  FLEN  data for rs1_i
- read_data2_o  out  FLEN  data for rs2_i
- read_data3_o  out  FLEN  data for rs3_i
- busy1_o  out  1  scoreboard busy bit for rs1_i
- busy2_o  out  1  scoreboard busy bit for rs2_i
- busy3_o  out  1  scoreboard busy bit for rs3_i
- issue_valid_i  in  1  an instruction with an FP destination is issuing
- issue_rd_i  in  5  destination of the issuing instruction
- wr_en_i  in  NUM_WR_PORTS  per-port write enable
- wr_addr_i  in  5*NUM_WR_PORTS  packed write addresses; port k uses bits [5k+4:5k]
- wr_data_i  in  FLEN*NUM_WR_PORTS  packed write data
- wr_single_i  in  NUM_WR_PORTS  per-port flag: write is single precision, NaN-box it
- wr_conflict_o  out  1  registered pulse: two ports wrote the same address

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.

States and reset:
- Two states: INIT and RUN.
- On rst_i, the next state is INIT, clr_cnt=0, ready_o=0, wr_conflict_o=0. Reset asserted mid-operation restarts INIT from 0.
- INIT: each cycle writes reg[clr_cnt]=0 and busy[clr_cnt]=0, then increments clr_cnt.
- When clr_cnt==31, the next state is RUN. ready_o goes 1 on the cycle after the clear of register 31 (33 cycles after rst_i deasserts, counting the rst_i cycle).
- In INIT, wr_en_i and issue_valid_i are ignored. read_data*_o=0 and busy*_o=1.

Reads:
- Combinational: read_dataN_o = reg[rsN_i].
- Without forwarding, a write is visible the cycle after its wr_en_i edge.

Writes:
- Write data is captured at the posedge when wr_en_i[k]=1 in RUN.
- NaN-boxing: if FLEN==64 and wr_single_i[k]=1, the stored value is {32'hFFFF_FFFF, wr_data[31:0]}. When FLEN==32, wr_single_i is ignored.
- Both ports writing the same address: the higher-index port wins. wr_conflict_o=1 for one cycle, otherwise 0.

Scoreboard:
- issue_valid_i in RUN sets busy[issue_rd_i] at the next edge.
- A port write to address A clears busy[A] at the same edge.
- Issue and write to the same register in one cycle: set wins, because a new producer supersedes the old one.
- busyN_o = busy[rsN_i], combinational.

Optional Feature:
- Macro: FRF_BYPASS_EN
- Defined:
  - A read address matching an active write port in the same cycle returns that port's post-NaN-box data.
  - The highest-index matching port has priority.
  - The matching busyN_o reads 0, unless issue_valid_i with issue_rd_i equal to that address is also present that cycle.
- Undefined: reads and busy bits reflect stored state only, so writes are visible one cycle later. No forwarding muxes are generated.

Test Plan:
- Reset and clear: write f5=0x3F80_0000, pulse rst_i for 1 cycle.
  - ready_o=0 until cycle 33.
  - Then read f5 returns 0 and busy1_o=0.
- NaN-box: FLEN=64, port0 writes f3 with wr_single_i=1 and data 0x0000_0000_4049_0FDB.
  - Next cycle read_data1_o=0xFFFF_FFFF_4049_0FDB.
  - With wr_single_i=0, the full 64-bit value is stored unchanged.
- Port conflict: port0 writes f7=0x1111_1111 and port1 writes f7=0x2222_2222 in the same cycle.
  - f7 reads 0x2222_2222.
  - wr_conflict_o=1 for exactly one cycle.
- Scoreboard: issue f9 at cycle N, so busy1_o=1 from N+1 (rs1_i=9). Port1 writes f9 at cycle N+3, so busy1_o=0 from N+4.
  - Issue and write f9 in the same cycle: busy stays 1.
- f0 writable: write f0=0x4000_0000 → read_data2_o=0x4000_0000 next cycle.
- Bypass (FRF_BYPASS_EN): rs3_i=12 while port0 writes f12=0xDEAD_BEEF.
  - read_data3_o=0xDEAD_BEEF in the same cycle.
  - Without the macro, the old value is returned that cycle and the new value on the next.
